// File: rtl/rgb_led_ctrl.sv
// RGB LED controller: debounced one-hot filter selection drives a PWM-dimmed,
// active-low colour output; illegal multi-hot selections blink red.
module rgb_led_ctrl #(
    parameter int unsigned NUM_FILTERS   = 5,
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned BLINK_DIV     = 25_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_FILTERS-1:0] SW,
    input  logic [PWM_BITS-1:0]    brightness,
    output logic [2:0]             color,
    output logic                   sel_valid,
    output logic [2:0]             sel_idx,
    output logic                   err
);

    localparam int unsigned DEB_W   = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(STABLE_CYCLES);
    localparam logic [DEB_W-1:0]   DEB_LOAD   = DEB_W'(STABLE_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [2:0] COL_OFF     = 3'b111;
    localparam logic [2:0] COL_RED     = 3'b011;
    localparam logic [2:0] COL_YELLOW  = 3'b001;
    localparam logic [2:0] COL_CYAN    = 3'b100;
    localparam logic [2:0] COL_MAGENTA = 3'b010;
    localparam logic [2:0] COL_BLUE    = 3'b110;
    localparam logic [2:0] COL_GREEN   = 3'b101;
    localparam logic [2:0] COL_WHITE   = 3'b000;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_FILTER = 2'd1,
        MODE_ERROR  = 2'd2
    } mode_t;

    logic [NUM_FILTERS-1:0] sync1;
    logic [NUM_FILTERS-1:0] sync2;
    logic [NUM_FILTERS-1:0] accepted;
    logic [DEB_W-1:0]       deb_cnt;
    logic                   sw_changed;

    logic [PWM_BITS-1:0]    pwm_cnt;
    logic                   pwm_on;
    logic [BLINK_W-1:0]     blink_cnt;
    logic                   blink_phase;

    mode_t                  mode;
    logic [2:0]             filt_idx;
    logic [2:0]             hot_cnt;
    logic [2:0]             base_color;

    logic [2:0]             color_nxt;
    logic                   sel_valid_nxt;
    logic [2:0]             sel_idx_nxt;
    logic                   err_nxt;

    // Two-flop synchroniser for the raw switches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= SW;
            sync2 <= sync1;
        end
    end

    // sync1 is the value sync2 takes next edge, so comparing them flags a change
    // one edge early and keeps the end-to-end latency at 2 + STABLE_CYCLES + 1.
    assign sw_changed = (sync1 != sync2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_cnt <= '0;
        end else if (sw_changed) begin
            deb_cnt <= '0;
        end else if (deb_cnt != DEB_MAX) begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accepted <= '0;
        end else if (!sw_changed && (deb_cnt == DEB_LOAD)) begin
            accepted <= sync2;
        end
    end

    // Mode decode: population count picks OFF / FILTER / ERROR
    always_comb begin
        hot_cnt  = 3'd0;
        filt_idx = 3'd0;
        for (int i = 0; i < int'(NUM_FILTERS); i++) begin
            if (accepted[i]) begin
                hot_cnt  = hot_cnt + 3'd1;
                filt_idx = 3'(i);
            end
        end
        if (hot_cnt == 3'd0) begin
            mode = MODE_OFF;
        end else if (hot_cnt == 3'd1) begin
            mode = MODE_FILTER;
        end else begin
            mode = MODE_ERROR;
        end
    end

    always_comb begin
        base_color = COL_OFF;
        case (mode)
            MODE_FILTER: begin
                case (filt_idx)
                    3'd0:    base_color = COL_YELLOW;
                    3'd1:    base_color = COL_CYAN;
                    3'd2:    base_color = COL_MAGENTA;
                    3'd3:    base_color = COL_BLUE;
                    3'd4:    base_color = COL_GREEN;
                    3'd5:    base_color = COL_WHITE;
                    default: base_color = COL_OFF;
                endcase
            end
            MODE_ERROR: base_color = COL_RED;
            default:    base_color = COL_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    assign pwm_on = (pwm_cnt < brightness);

    // Blink timer idles at (0, lit) so entering ERROR starts a full lit half-period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (mode != MODE_ERROR) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BLINK_W'(1);
        end
    end

    always_comb begin
        color_nxt     = COL_OFF;
        sel_valid_nxt = (mode == MODE_FILTER);
        sel_idx_nxt   = (mode == MODE_FILTER) ? filt_idx : 3'd0;
        err_nxt       = (mode == MODE_ERROR);
        if (pwm_on && ((mode != MODE_ERROR) || blink_phase)) begin
            color_nxt = base_color;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color     <= COL_OFF;
            sel_valid <= 1'b0;
            sel_idx   <= 3'd0;
            err       <= 1'b0;
        end else begin
            color     <= color_nxt;
            sel_valid <= sel_valid_nxt;
            sel_idx   <= sel_idx_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_rgb_led_ctrl.sv
// Directed bench for rgb_led_ctrl with small parameters so debounce, PWM and
// blink periods are a handful of cycles.
module tb_rgb_led_ctrl;

    localparam int unsigned NF = 5;
    localparam int unsigned PB = 3;

    logic          clk;
    logic          reset;
    logic [NF-1:0] sw;
    logic [PB-1:0] bri;
    logic [2:0]    color;
    logic          sel_valid;
    logic [2:0]    sel_idx;
    logic          err;

    int checks;
    int failures;
    int n_edges;

    rgb_led_ctrl #(
        .NUM_FILTERS  (5),
        .PWM_BITS     (3),
        .STABLE_CYCLES(4),
        .BLINK_DIV    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .SW        (sw),
        .brightness(bri),
        .color     (color),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; the DUT PWM counter shares this origin
    always @(posedge clk or posedge reset) begin
        if (reset) n_edges <= 0;
        else       n_edges <= n_edges + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Colour expected after edge number edge_n, given base colour and duty
    function automatic logic [2:0] pwm_gate(input logic [2:0] base, input logic [2:0] b,
                                            input int edge_n);
        int cnt;
        cnt = (edge_n - 1) % 8;
        return (cnt < int'(b)) ? base : 3'b111;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        sw    = 5'b00000;
        bri   = 3'd7;
        tick();
        tick();
        checks++;
        if (color !== 3'b111 || sel_valid !== 1'b0 || sel_idx !== 3'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold color=%b sel_valid=%b sel_idx=%0d err=%b want 111/0/0/0",
                     color, sel_valid, sel_idx, err);
        end
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (color !== 3'b111 || sel_valid !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL idle_off edge=%0d color=%b sel_valid=%b err=%b want 111/0/0",
                         n_edges, color, sel_valid, err);
            end
        end
    endtask

    task automatic test_select();
        int dark;
        dark = 0;
        sw   = 5'b00010;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (color !== 3'b111 || sel_valid !== 1'b0) begin
                failures++;
                $display("FAIL select_early k=%0d color=%b sel_valid=%b want 111/0",
                         k, color, sel_valid);
            end
        end
        tick();
        checks++;
        if (sel_valid !== 1'b1 || sel_idx !== 3'd1 || err !== 1'b0 ||
            color !== pwm_gate(3'b100, 3'd7, n_edges)) begin
            failures++;
            $display("FAIL select_latency color=%b sel_valid=%b sel_idx=%0d err=%b want %b/1/1/0",
                     color, sel_valid, sel_idx, err, pwm_gate(3'b100, 3'd7, n_edges));
        end
        for (int k = 0; k < 16; k++) begin
            tick();
            if (color === 3'b111) dark++;
            checks++;
            if (color !== pwm_gate(3'b100, 3'd7, n_edges) || sel_idx !== 3'd1) begin
                failures++;
                $display("FAIL select_pwm edge=%0d color=%b sel_idx=%0d want %b/1",
                         n_edges, color, sel_idx, pwm_gate(3'b100, 3'd7, n_edges));
            end
        end
        checks++;
        if (dark !== 2) begin
            failures++;
            $display("FAIL select_duty dark_cycles=%0d want 2", dark);
        end
    endtask

    task automatic test_bounce();
        sw = 5'b00000;
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (color !== 3'b111 || sel_valid !== 1'b0) begin
            failures++;
            $display("FAIL bounce_settle color=%b sel_valid=%b want 111/0", color, sel_valid);
        end
        sw = 5'b00100;
        for (int k = 0; k < 3; k++) tick();
        sw = 5'b00000;
        for (int k = 0; k < 15; k++) begin
            tick();
            checks++;
            if (color !== 3'b111 || sel_valid !== 1'b0 || sel_idx !== 3'd0 || err !== 1'b0) begin
                failures++;
                $display("FAIL bounce_ignored k=%0d color=%b sel_valid=%b sel_idx=%0d err=%b want 111/0/0/0",
                         k, color, sel_valid, sel_idx, err);
            end
        end
    endtask

    // Expects err to rise on the 7th edge, then 8 lit / 8 dark blink cycles
    task automatic check_error_blink(input string tag);
        logic [2:0] want;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (err !== 1'b0 || color !== 3'b111) begin
                failures++;
                $display("FAIL %s_early k=%0d err=%b color=%b want 0/111", tag, k, err, color);
            end
        end
        for (int j = 0; j < 32; j++) begin
            tick();
            want = (((j / 8) % 2) == 0) ? pwm_gate(3'b011, bri, n_edges) : 3'b111;
            checks++;
            if (err !== 1'b1 || sel_valid !== 1'b0 || sel_idx !== 3'd0 || color !== want) begin
                failures++;
                $display("FAIL %s_blink j=%0d err=%b sel_valid=%b sel_idx=%0d color=%b want 1/0/0/%b",
                         tag, j, err, sel_valid, sel_idx, color, want);
            end
        end
    endtask

    task automatic test_error();
        sw  = 5'b00011;
        bri = 3'd7;
        check_error_blink("error");
    endtask

    task automatic test_dim();
        sw  = 5'b10000;
        bri = 3'd0;
        for (int k = 0; k < 7; k++) tick();
        checks++;
        if (sel_valid !== 1'b1 || sel_idx !== 3'd4 || err !== 1'b0) begin
            failures++;
            $display("FAIL dim_select sel_valid=%b sel_idx=%0d err=%b want 1/4/0",
                     sel_valid, sel_idx, err);
        end
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++;
            if (color !== 3'b111) begin
                failures++;
                $display("FAIL dim_zero edge=%0d color=%b want 111", n_edges, color);
            end
        end
        bri = 3'd4;
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++;
            if (color !== pwm_gate(3'b101, 3'd4, n_edges)) begin
                failures++;
                $display("FAIL dim_half edge=%0d color=%b want %b",
                         n_edges, color, pwm_gate(3'b101, 3'd4, n_edges));
            end
        end
    endtask

    task automatic test_reset_mid_error();
        sw  = 5'b00011;
        bri = 3'd7;
        for (int k = 0; k < 12; k++) tick();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL mid_error_setup err=%b want 1", err);
        end
        reset = 1'b1;
        #2;
        checks++;
        if (color !== 3'b111 || sel_valid !== 1'b0 || sel_idx !== 3'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset color=%b sel_valid=%b sel_idx=%0d err=%b want 111/0/0/0",
                     color, sel_valid, sel_idx, err);
        end
        tick();
        tick();
        reset = 1'b0;
        check_error_blink("rst_error");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        sw       = '0;
        bri      = '0;
        test_reset();
        test_select();
        test_bounce();
        test_error();
        test_dim();
        test_reset_mid_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_led_ctrl.md
RGB_LED_CTRL -- requirements
Module: rgb_led_ctrl

Parameters
REQ-001 SHALL: NUM_FILTERS, default 5, number of filter-select switches; legal range 1..6.
REQ-002 SHALL: PWM_BITS, default 8, width of brightness and PWM counter.
REQ-003 SHALL: STABLE_CYCLES, default 1000, debounce hold time in clk cycles; minimum 1.
REQ-004 SHALL: BLINK_DIV, default 25_000_000, blink half-period in clk cycles; minimum 1.

Interface
REQ-005 SHALL: clk  input  1  sole clock, all state rising-edge.
REQ-006 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL: SW  input  NUM_FILTERS  raw, asynchronous filter-select switches, bit i = filter i.
REQ-008 SHALL: brightness  input  PWM_BITS  synchronous duty setting.
REQ-009 SHALL: color  output  3  {R,G,B} LED drive, active-low (0 = lit), registered.
REQ-010 SHALL: sel_valid  output  1  accepted selection is exactly one-hot, registered.
REQ-011 SHALL: sel_idx  output  3  index of the accepted one-hot bit, 0 when not valid, registered.
REQ-012 SHALL: err  output  1  accepted selection has two or more bits set, registered.

Function
REQ-013 SHALL: SW pass through a 2-flop synchroniser before any other use.
REQ-014 SHALL: a debounce counter clear to 0 whenever the synchronised value differs from its previous-cycle value, and otherwise increment, saturating at STABLE_CYCLES.
REQ-015 SHALL: the accepted selection load the synchronised value on the edge where the counter equals STABLE_CYCLES-1 and the value is unchanged; the accepted selection is otherwise held.
REQ-016 SHALL: outputs reflect a new accepted selection one edge after it loads, giving total latency 2 + STABLE_CYCLES + 1 edges from a stable SW change.
REQ-017 SHALL: decode the accepted selection into exactly one mode: OFF when all zero, FILTER(i) when one-hot at bit i, ERROR when multi-hot.
REQ-018 SHALL: base colour per FILTER index be 0 YELLOW 3'b001, 1 CYAN 3'b100, 2 MAGENTA 3'b010, 3 BLUE 3'b110, 4 GREEN 3'b101, 5 WHITE 3'b000.
REQ-019 SHALL: base colour be OFF 3'b111 in mode OFF and RED 3'b011 in mode ERROR.
REQ-020 SHALL: a free-running PWM_BITS counter wrap from all-ones to 0; the pwm_on signal is high when counter < brightness (brightness 0 -> never lit; all-ones -> lit 2^PWM_BITS-1 of every 2^PWM_BITS cycles).
REQ-021 SHALL: in ERROR a blink counter count 0..BLINK_DIV-1 and toggle blink_phase on wrap; blink_phase = 1 means lit.
REQ-022 SHALL: on entry to ERROR the blink counter and blink_phase load 0 and 1 respectively, so the first lit half-period is a full BLINK_DIV cycles.
REQ-023 SHALL: outside ERROR the blink counter and blink_phase be held at 0 and 1.
REQ-024 SHALL: next color be base colour when pwm_on and (mode != ERROR or blink_phase), else 3'b111.
REQ-025 SHALL: sel_valid, sel_idx and err update on the same edge as the corresponding colour change.
REQ-026 SHALL: SW bouncing (any change before hold completes) never change the accepted selection.
REQ-027 SHALL: a brightness change take effect on the next PWM comparison with no resynchronisation.

Reset
REQ-028 SHALL: reset asserted force immediately, without waiting for clk, color=3'b111, sel_valid=0, sel_idx=0, err=0.
REQ-029 SHALL: reset clear synchroniser flops, debounce counter, accepted selection, PWM counter and blink counter to 0, and set blink_phase=1.
REQ-030 SHALL: reset mid-debounce or mid-blink discard all progress; after release a held SW requires the full 2 + STABLE_CYCLES + 1 latency.

Verification (bench parameters NUM_FILTERS=5, PWM_BITS=3, STABLE_CYCLES=4, BLINK_DIV=8)
REQ-031 SHALL: reset, SW=00000, brightness=7 -> color=111, sel_valid=0, err=0 indefinitely.
REQ-032 SHALL: SW 00000->00010 held, brightness=7 -> color=100 exactly 7 edges later, then 111 one cycle in 8; sel_valid=1, sel_idx=1.
REQ-033 SHALL: SW=00100 pulsed for 3 cycles then back to 0 -> accepted selection never changes, color stays 111.
REQ-034 SHALL: SW=00011 held, brightness=7 -> err=1, color 011 (PWM-gated) for 8 cycles, then 111 for 8, repeating.
REQ-035 SHALL: SW=10000, brightness=0 -> sel_idx=4, sel_valid=1, color=111 always; brightness=4 -> color=101 on PWM counts 0..3, 111 on counts 4..7.
REQ-036 SHALL: reset asserted mid-ERROR blink -> outputs at reset values asynchronously; after release with SW still 00011 -> err=1 after 7 edges, lit phase a full 8 cycles.
